// File: rtl/adder_share_arb_if.sv
// Handshake bundle for the shared adder arbiter.
// Requesters drive operands/requests; the arbiter returns grant and result.
interface adder_share_arb_if #(
    parameter int SIZE  = 4,
    parameter int N_REQ = 4
);
    localparam int ID_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;

    logic                  en;
    logic [N_REQ-1:0]      req;
    logic [N_REQ*SIZE-1:0] a_flat;
    logic [N_REQ*SIZE-1:0] b_flat;
    logic [N_REQ-1:0]      cin;
    logic [N_REQ-1:0]      gnt;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [SIZE-1:0]       sum;
    logic                  cout;

    modport master (
        output en, req, a_flat, b_flat, cin,
        input  gnt, rsp_valid, rsp_id, sum, cout
    );

    modport slave (
        input  en, req, a_flat, b_flat, cin,
        output gnt, rsp_valid, rsp_id, sum, cout
    );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one SIZE-bit adder among N_REQ requesters.
// Grant is combinational; result is registered one cycle after the grant.
module adder_share_arb #(
    parameter int SIZE  = 4,
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arb_if.slave bus
);
    localparam int ID_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             vld_q, vld_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [SIZE-1:0]  sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [N_REQ-1:0] gnt_c;
    logic [ID_W-1:0]  sel_c;
    logic [ID_W:0]    raw;
    logic [ID_W-1:0]  cand;
    logic [SIZE-1:0]  a_sel, b_sel;
    logic             c_sel;

    // Search from ptr upward with wrap; first active requester wins.
    always_comb begin
        gnt_c = '0;
        sel_c = '0;
        raw   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            raw = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (raw >= (ID_W+1)'(N_REQ)) begin
                raw = raw - (ID_W+1)'(N_REQ);
            end
            cand = raw[ID_W-1:0];
            if (bus.en && (gnt_c == '0) && bus.req[cand]) begin
                gnt_c[cand] = 1'b1;
                sel_c       = cand;
            end
        end
    end

    // One-hot operand mux for the granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_c[i]) begin
                a_sel = a_sel | bus.a_flat[i*SIZE +: SIZE];
                b_sel = b_sel | bus.b_flat[i*SIZE +: SIZE];
                c_sel = c_sel | bus.cin[i];
            end
        end
    end

    // Next state: a transfer advances the pointer and loads the result.
    always_comb begin
        ptr_d  = ptr_q;
        vld_d  = 1'b0;
        id_d   = id_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (|gnt_c) begin
            ptr_d = (sel_c == ID_W'(N_REQ - 1)) ? '0 : sel_c + ID_W'(1);
            vld_d = 1'b1;
            id_d  = sel_c;
            {cout_d, sum_d} = {1'b0, a_sel} + {1'b0, b_sel}
                            + (SIZE+1)'(c_sel);
        end
    end

    // State and result registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            id_q   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            id_q   <= id_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_id    = id_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb (SIZE=4, N_REQ=4).
// Vector table plus hand sequences for fairness and mid-stream reset.
module tb_adder_share_arb;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    adder_share_arb_if #(.SIZE(4), .N_REQ(4)) bus ();

    adder_share_arb #(.SIZE(4), .N_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  cin;
        logic [3:0]  gnt;
        logic        vld;
        logic [1:0]  id;
        logic [3:0]  sum;
        logic        cout;
    } vec_t;

    vec_t tv [11];

    logic [3:0] f_gnt [5];
    logic [1:0] f_id  [5];
    logic [3:0] f_sum [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] req,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] cin);
        bus.en     = en;
        bus.req    = req;
        bus.a_flat = a;
        bus.b_flat = b;
        bus.cin    = cin;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // en req a b cin | gnt vld id sum cout
        tv[0]  = '{1'b1, 4'b0100, 16'h0900, 16'h0800, 4'b0100,
                   4'b0100, 1'b1, 2'd2, 4'h2, 1'b1};
        tv[1]  = '{1'b1, 4'b0000, 16'h0900, 16'h0800, 4'b0100,
                   4'b0000, 1'b0, 2'd2, 4'h2, 1'b1};
        tv[2]  = '{1'b0, 4'b1111, 16'hF070, 16'hF050, 4'b1000,
                   4'b0000, 1'b0, 2'd2, 4'h2, 1'b1};
        tv[3]  = '{1'b0, 4'b1111, 16'hF070, 16'hF050, 4'b1000,
                   4'b0000, 1'b0, 2'd2, 4'h2, 1'b1};
        tv[4]  = '{1'b0, 4'b1111, 16'hF070, 16'hF050, 4'b1000,
                   4'b0000, 1'b0, 2'd2, 4'h2, 1'b1};
        tv[5]  = '{1'b1, 4'b1111, 16'hF070, 16'hF050, 4'b1000,
                   4'b1000, 1'b1, 2'd3, 4'hF, 1'b1};
        tv[6]  = '{1'b1, 4'b1111, 16'hF070, 16'hF050, 4'b1000,
                   4'b0001, 1'b1, 2'd0, 4'h0, 1'b0};
        tv[7]  = '{1'b1, 4'b0010, 16'hF070, 16'hF050, 4'b1000,
                   4'b0010, 1'b1, 2'd1, 4'hC, 1'b0};
        tv[8]  = '{1'b1, 4'b1010, 16'hF070, 16'hF050, 4'b1000,
                   4'b1000, 1'b1, 2'd3, 4'hF, 1'b1};
        tv[9]  = '{1'b1, 4'b1010, 16'hF070, 16'hF050, 4'b1000,
                   4'b0010, 1'b1, 2'd1, 4'hC, 1'b0};
        tv[10] = '{1'b1, 4'b0000, 16'hF070, 16'hF050, 4'b1000,
                   4'b0000, 1'b0, 2'd1, 4'hC, 1'b0};

        f_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        f_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        f_sum = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h2};

        // Reset state, checked before any clock edge.
        rst_n = 1'b0;
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'b0);
        #2;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_id",    32'(bus.rsp_id),    32'd0);
        chk("rst_sum",   32'(bus.sum),       32'd0);
        chk("rst_cout",  32'(bus.cout),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: single request, enable gating, carry bounds, skip/wrap.
        for (int i = 0; i < 11; i++) begin
            drive(tv[i].en, tv[i].req, tv[i].a, tv[i].b, tv[i].cin);
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(tv[i].gnt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vld", i), 32'(bus.rsp_valid),
                32'(tv[i].vld));
            chk($sformatf("v%0d_id", i), 32'(bus.rsp_id), 32'(tv[i].id));
            chk($sformatf("v%0d_sum", i), 32'(bus.sum), 32'(tv[i].sum));
            chk($sformatf("v%0d_cout", i), 32'(bus.cout),
                32'(tv[i].cout));
        end

        // Fairness from reset with all requesters active.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(1'b1, 4'b1111, 16'h4321, 16'h1111, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr%0d_gnt", i), 32'(bus.gnt), 32'(f_gnt[i]));
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_vld", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("rr%0d_id", i), 32'(bus.rsp_id), 32'(f_id[i]));
            chk($sformatf("rr%0d_sum", i), 32'(bus.sum), 32'(f_sum[i]));
        end

        // One more grant brings ptr to 2, then reset mid-cycle.
        #1;
        chk("pre_gnt", 32'(bus.gnt), 32'b0010);
        @(posedge clk);
        #1;
        chk("pre_vld", 32'(bus.rsp_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_vld",  32'(bus.rsp_valid), 32'd0);
        chk("mid_id",   32'(bus.rsp_id),    32'd0);
        chk("mid_sum",  32'(bus.sum),       32'd0);
        chk("mid_cout", 32'(bus.cout),      32'd0);
        chk("mid_gnt",  32'(bus.gnt),       32'b0001);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("rel_vld", 32'(bus.rsp_valid), 32'd0);
        chk("rel_gnt", 32'(bus.gnt),       32'b0001);
        @(posedge clk);
        #1;
        chk("post_vld", 32'(bus.rsp_valid), 32'd1);
        chk("post_id",  32'(bus.rsp_id),    32'd0);
        chk("post_sum", 32'(bus.sum),       32'd2);
        chk("post_gnt", 32'(bus.gnt),       32'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
